// File: rtl/pie_tx_sequencer.sv
// pie_tx_sequencer: frames MAC commands into PIE encoder bit strobes, with post-frame gap
// Ports: clk, rst (async, active-high); cmd_valid/cmd_ready/cmd_data/cmd_len/cmd_preamble/cmd_crc16
// command handshake; enc_rst/enc_preamble/enc_bit/enc_rdy encoder side; busy, frame_done status.
// Optional CRC-16/CCITT trailer is built only when PIE_SEQ_CRC16_EN is defined.
module pie_tx_sequencer #(
  parameter int MAX_BITS   = 64,
  parameter int LEN_W      = 7,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [MAX_BITS-1:0] cmd_data,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                cmd_preamble,
  input  logic                cmd_crc16,
  output logic                enc_rst,
  output logic                enc_preamble,
  output logic                enc_bit,
  input  logic                enc_rdy,
  output logic                busy,
  output logic                frame_done
);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  typedef enum logic [2:0] {IDLE, RUN, CRC, TAIL, GAP} state_t;
  state_t state, next;
  logic [MAX_BITS-1:0] shreg;
  logic [LEN_W-1:0] cnt, len_eff;
  logic [GW-1:0] gap_cnt;
  logic accept, crc_req, use_crc, crc_msb, crc_last;
  assign accept    = cmd_valid & cmd_ready;
  assign len_eff   = cmd_len > LEN_W'(MAX_BITS) ? LEN_W'(MAX_BITS) : cmd_len;
  assign cmd_ready = state == IDLE;
  assign busy      = state == RUN || state == CRC || state == TAIL;
  // reset state is IDLE, so the encoder is parked asynchronously on rst
  assign enc_rst   = state == IDLE || state == GAP;
`ifdef PIE_SEQ_CRC16_EN
  logic [15:0] crc;
  logic [3:0] crc_cnt;
  assign crc_req  = cmd_crc16;
  assign crc_msb  = ~crc[15];
  assign crc_last = crc_cnt == 4'd15;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      use_crc <= 1'b0;
      crc     <= 16'hFFFF;
      crc_cnt <= '0;
    end else if (accept) begin
      use_crc <= cmd_crc16;
      crc     <= 16'hFFFF;
      crc_cnt <= '0;
    end else if (enc_rdy && state == RUN) begin
      crc <= {crc[14:0], 1'b0} ^ ({16{crc[15] ^ shreg[MAX_BITS-1]}} & 16'h1021);
    end else if (enc_rdy && state == CRC) begin
      crc     <= {crc[14:0], 1'b0};
      crc_cnt <= crc_cnt + 4'd1;
    end
`else
  logic unused_crc16;
  assign unused_crc16 = cmd_crc16;
  assign crc_req  = 1'b0;
  assign use_crc  = 1'b0;
  assign crc_msb  = 1'b0;
  assign crc_last = 1'b1;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next    = state;
    enc_bit = 1'b0;
    case (state)
      IDLE: if (accept) next = len_eff == '0 ? (crc_req ? CRC : TAIL) : RUN;
      RUN: begin
        enc_bit = shreg[MAX_BITS-1];
        if (enc_rdy && cnt == LEN_W'(1)) next = use_crc ? CRC : TAIL;
      end
      CRC: begin
        enc_bit = crc_msb;
        if (enc_rdy && crc_last) next = TAIL;
      end
      TAIL: if (enc_rdy) next = GAP;
      GAP: if (gap_cnt == GW'(GAP_CYCLES)) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shreg        <= '0;
      cnt          <= '0;
      enc_preamble <= 1'b0;
      frame_done   <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      frame_done <= state == TAIL && enc_rdy;
      gap_cnt    <= state == GAP ? gap_cnt + 1'b1 : '0;
      if (accept) begin
        shreg        <= cmd_data;
        cnt          <= len_eff;
        enc_preamble <= cmd_preamble;
      end else if (state == RUN && enc_rdy) begin
        shreg <= {shreg[MAX_BITS-2:0], 1'b0};
        cnt   <= cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_pie_tx_sequencer.sv
// tb_pie_tx_sequencer: scoreboard bench for pie_tx_sequencer with directed frames
module tb_pie_tx_sequencer;
  localparam int G = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_preamble = 1'b0, cmd_crc16 = 1'b0;
  logic [63:0] cmd_data = '0;
  logic [6:0] cmd_len = '0;
  logic enc_rst, enc_preamble, enc_bit, enc_rdy = 1'b0, busy, frame_done;
  int checks = 0, errors = 0, cyc = 0, g;
  typedef struct { int n; logic [127:0] bits; logic pre; } exp_t;
  exp_t sb[$];

  pie_tx_sequencer #(.MAX_BITS(64), .LEN_W(7), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_len(cmd_len), .cmd_preamble(cmd_preamble), .cmd_crc16(cmd_crc16), .enc_rst(enc_rst),
    .enc_preamble(enc_preamble), .enc_bit(enc_bit), .enc_rdy(enc_rdy), .busy(busy),
    .frame_done(frame_done));

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #2ms; $display("FAIL watchdog got=timeout exp=finish"); $fatal(1); end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] d, input logic [6:0] l, input logic p, input logic c);
    exp_t e;
    logic [15:0] crc;
    logic use_c, fb;
    int n;
    n = l > 64 ? 64 : int'(l);
    e.bits = '0;
    e.pre = p;
    crc = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      e.bits[i] = d[63-i];
      fb = crc[15] ^ d[63-i];
      crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    use_c = c;
`ifndef PIE_SEQ_CRC16_EN
    use_c = 1'b0;
`endif
    if (use_c) begin
      for (int j = 0; j < 16; j++) e.bits[n+j] = ~crc[15-j];
      n += 16;
    end
    e.n = n;
    return e;
  endfunction

  // monitor: collects consumed symbols, checks each frame on frame_done
  initial begin
    logic [127:0] got, mask;
    int ngot, last;
    exp_t e;
    ngot = 0; got = '0; last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ngot = 0; got = '0;
      end else begin
        if (enc_rdy && busy) begin
          got[ngot] = enc_bit; ngot++; last = cyc;
        end
        if (frame_done) begin
          if (sb.size() == 0) chk("unexpected_frame_done", 1, 0);
          else begin
            e = sb.pop_front();
            mask = '0;
            for (int i = 0; i < e.n; i++) mask[i] = 1'b1;
            chk("strobe_count", ngot, e.n + 1);
            chk("frame_bits", got & mask, e.bits);
            chk("frame_preamble", enc_preamble, e.pre);
            chk("frame_done_timing", cyc, last + 1);
          end
          ngot = 0; got = '0;
        end
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [6:0] l, input logic p, input logic c, input bit push);
    int k = 0;
    while (!cmd_ready && k < 2000) begin @(posedge clk); #1; k++; end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_data = d; cmd_len = l; cmd_preamble = p; cmd_crc16 = c;
    if (push) sb.push_back(mk(d, l, p, c));
    @(posedge clk); #1;
    cmd_valid = 0; cmd_data = ~d; cmd_len = 7'd9; cmd_preamble = ~p;
    chk("busy_after_accept", busy, 1);
    chk("enc_rst_low", enc_rst, 0);
  endtask

  task automatic run_enc(input logic p, output int n_gap);
    int k = 0;
    while (k < 300) begin
      chk("ready_low_busy", cmd_ready, 0);
      chk("enc_preamble_hold", enc_preamble, p);
      enc_rdy = 1; @(posedge clk); #1; enc_rdy = 0;
      if (!busy) break;
      @(posedge clk); #1; k++;
    end
    chk("frame_end", busy, 0);
    chk("enc_rst_parked", enc_rst, 1);
    n_gap = 0;
    while (!cmd_ready && n_gap < 2000) begin @(posedge clk); #1; n_gap++; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_enc_rst", enc_rst, 1);
    chk("rst_enc_preamble", enc_preamble, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    @(posedge clk); #1;
    send({4'b1011, 60'h0}, 7'd4, 1, 0, 1);
    run_enc(1, g);
    chk("gap_t1", g, G + 1);
    send(64'hFFFF_0000_FFFF_0000, 7'd0, 0, 0, 1);
    run_enc(0, g);
    chk("gap_len0", g, G + 1);
    send({8'h96, 56'h0}, 7'd8, 1, 1, 1);
    run_enc(1, g);
    chk("gap_crcflag", g, G + 1);
    send(64'hA5C3_0F1E_9B7D_2468, 7'd100, 0, 0, 1);
    run_enc(0, g);
    chk("gap_clamp", g, G + 1);
    send({3'b110, 61'h0}, 7'd3, 1, 0, 1);
    sb.push_back(mk({5'b01101, 59'h0}, 7'd5, 0, 0));
    cmd_data = {5'b01101, 59'h0}; cmd_len = 7'd5; cmd_preamble = 0; cmd_crc16 = 0; cmd_valid = 1;
    run_enc(1, g);
    chk("gap_held", g, G + 1);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_data = '1;
    chk("held_accept", busy, 1);
    run_enc(0, g);
    chk("gap_second", g, G + 1);
    send({8'hF0, 56'h0}, 7'd8, 0, 0, 0);
    repeat (2) begin enc_rdy = 1; @(posedge clk); #1; enc_rdy = 0; @(posedge clk); #1; end
    rst = 1; #1;
    chk("abort_enc_rst", enc_rst, 1);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1 rst = 0;
    chk("abort_ready", cmd_ready, 1);
    repeat (4) begin @(posedge clk); #1; chk("abort_no_done", frame_done, 0); end
    send({3'b101, 61'h0}, 7'd3, 1, 0, 1);
    run_enc(1, g);
    chk("gap_after_abort", g, G + 1);
`ifdef PIE_SEQ_CRC16_EN
    send(64'h0, 7'd0, 0, 1, 1);
    run_enc(0, g);
    send({22'b1000_0001_0010_0000_0011_01, 42'h0}, 7'd22, 1, 1, 1);
    run_enc(1, g);
`endif
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
